// File: rtl/window_gen_3x3.sv
// window_gen_3x3 - streaming 3x3 neighbourhood generator.
//
// Takes a raster-order 24-bit pixel stream, keeps the two previous lines in
// line buffers and presents a 3x3 window around centre (x-1, y-1) for every
// accepted beat at (x, y) with x >= 2 and y >= 2. Fixed 2-cycle latency,
// 1 pixel/clock, no backpressure, no border padding.
//
// Ports:
//   clk                  pixel clock
//   n_rst                synchronous active-low reset
//   in_valid             input beat qualifier
//   in_sof               first pixel of frame (qualified by in_valid)
//   in_pixel[23:0]       pixel data, passed through unmodified
//   window_0..window_8   row-major window: 0..2 oldest line, 6..8 current
//                        line, left to right; window_4 is the centre
//   out_valid            window valid this cycle
//   out_sof / out_eof    first / last window of the frame
//   out_x / out_y        centre coordinate (only with WINDOW_COORD_OUT_EN)
//
// Optional feature macro: WINDOW_COORD_OUT_EN adds out_x/out_y.

module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [23:0] in_pixel,
  output logic [23:0] window_0,
  output logic [23:0] window_1,
  output logic [23:0] window_2,
  output logic [23:0] window_3,
  output logic [23:0] window_4,
  output logic [23:0] window_5,
  output logic [23:0] window_6,
  output logic [23:0] window_7,
  output logic [23:0] window_8,
  output logic        out_valid,
  output logic        out_sof,
`ifdef WINDOW_COORD_OUT_EN
  output logic        out_eof,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_y
`else
  output logic        out_eof
`endif
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  localparam logic [0:0] WAIT_SOF = 1'b0;
  localparam logic [0:0] ACTIVE   = 1'b1;

  logic [0:0]    state;
  logic [XW-1:0] x, cur_x;
  logic [YW-1:0] y, cur_y;
  logic          accept, line_end, frame_end;

  // An in_sof beat always restarts at (0,0), whatever the current state.
  always_comb begin
    accept    = in_valid && ((state == ACTIVE) || in_sof);
    cur_x     = in_sof ? '0 : x;
    cur_y     = in_sof ? '0 : y;
    line_end  = (cur_x == XW'(IMG_WIDTH - 1));
    frame_end = line_end && (cur_y == YW'(IMG_HEIGHT - 1));
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= WAIT_SOF;
      x     <= '0;
      y     <= '0;
    end else if (accept) begin
      if (frame_end) begin
        x     <= '0;
        y     <= '0;
        state <= WAIT_SOF;
      end else if (line_end) begin
        x     <= '0;
        y     <= cur_y + YW'(1);
        state <= ACTIVE;
      end else begin
        x     <= cur_x + XW'(1);
        y     <= cur_y;
        state <= ACTIVE;
      end
    end
  end

  // Line buffers: lb_a holds line y-1, lb_b holds line y-2. Read-before-write
  // lets lb_b take the old lb_a entry in the same access.
  logic [23:0] lb_a [IMG_WIDTH];
  logic [23:0] lb_b [IMG_WIDTH];
  logic [23:0] rd_a, rd_b;

  always_ff @(posedge clk) begin
    if (accept) begin
      rd_a         <= lb_a[cur_x];
      rd_b         <= lb_b[cur_x];
      lb_a[cur_x]  <= in_pixel;
      lb_b[cur_x]  <= lb_a[cur_x];
    end
  end

  // Stage 1: beat attributes aligned with the RAM read data.
  logic        s1_valid, s1_win, s1_sof, s1_eof;
  logic [23:0] pix_d;
`ifdef WINDOW_COORD_OUT_EN
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_valid <= 1'b0;
      s1_win   <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
      pix_d    <= '0;
`ifdef WINDOW_COORD_OUT_EN
      s1_x     <= '0;
      s1_y     <= '0;
`endif
    end else begin
      s1_valid <= accept;
      s1_win   <= (cur_x >= XW'(2)) && (cur_y >= YW'(2));
      s1_sof   <= (cur_x == XW'(2)) && (cur_y == YW'(2));
      s1_eof   <= frame_end;
      pix_d    <= in_pixel;
`ifdef WINDOW_COORD_OUT_EN
      s1_x     <= cur_x - XW'(1);
      s1_y     <= cur_y - YW'(1);
`endif
    end
  end

  // Stage 2: shift rows advance only on accepted beats, so gaps hold the window.
  logic [23:0] top [3];
  logic [23:0] mid [3];
  logic [23:0] bot [3];
  logic        emit;

  assign emit = s1_valid && s1_win;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < 3; i++) begin
        top[i] <= '0;
        mid[i] <= '0;
        bot[i] <= '0;
      end
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
`ifdef WINDOW_COORD_OUT_EN
      out_x     <= '0;
      out_y     <= '0;
`endif
    end else begin
      if (s1_valid) begin
        top[0] <= top[1];
        top[1] <= top[2];
        top[2] <= rd_b;
        mid[0] <= mid[1];
        mid[1] <= mid[2];
        mid[2] <= rd_a;
        bot[0] <= bot[1];
        bot[1] <= bot[2];
        bot[2] <= pix_d;
      end
      out_valid <= emit;
      out_sof   <= emit && s1_sof;
      out_eof   <= emit && s1_eof;
`ifdef WINDOW_COORD_OUT_EN
      if (emit) begin
        out_x <= s1_x;
        out_y <= s1_y;
      end
`endif
    end
  end

  assign window_0 = top[0];
  assign window_1 = top[1];
  assign window_2 = top[2];
  assign window_3 = mid[0];
  assign window_4 = mid[1];
  assign window_5 = mid[2];
  assign window_6 = bot[0];
  assign window_7 = bot[1];
  assign window_8 = bot[2];

endmodule
